mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Parametrised iterative multiply/divide unit owning the HI/LO registers of the multi-cycle MIPS core.
//  Runs MULT/MULTU/DIV/DIVU one bit per cycle under a start/busy/done handshake with the sequence controller.
//  Adds over the current mult/div path: generic WIDTH, div-by-zero flag, MTHI/MTLO write port, optional MADD.
// PARAMETERS
//  WIDTH    32   operand, HI and LO width (>=4)
//  CNT_W    $clog2(WIDTH)   iteration counter width (derived, not overridden)
// PORTS
//  CLK       in   1      clock, all logic on rising edge
//  RST       in   1      synchronous, active-low reset
//  start     in   1      launch op; accepted only when busy==0
//  op        in   3      0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MADD, 5 MADDU, others ignored
//  a         in   WIDTH  rs operand (multiplicand / dividend), sampled on accept edge
//  b         in   WIDTH  rt operand (multiplier / divisor), sampled on accept edge
//  hi_we     in   1      MTHI: hi <= wdata; ignored while busy or when start accepted same cycle
//  lo_we     in   1      MTLO: lo <= wdata; same rules as hi_we
//  wdata     in   WIDTH  MTHI/MTLO data
//  busy      out  1      operation in flight
//  done      out  1      one-cycle pulse, hi/lo hold the new result in that cycle
//  div0      out  1      registered with done: 1 if completed DIV/DIVU had b==0, else 0
//  hi        out  WIDTH  HI register
//  lo        out  WIDTH  LO register
// BEHAVIOUR
//  Reset (RST==0 at edge): state IDLE, busy=0, done=0, div0=0, hi=0, lo=0; aborts any op, no done follows.
//  FSM IDLE -> RUN -> FIX -> IDLE. busy = (state!=IDLE).
//   IDLE: start&&valid op -> capture |a|,|b| (signed ops) or raw, result signs, counter=0 -> RUN.
//   RUN: one shift-add (mult) or restoring subtract-shift (div) step per cycle; WIDTH steps, then FIX.
//   FIX: apply sign correction, write hi/lo, done=1, div0 set -> IDLE.
//  Latency: start accepted at edge k -> done=1 and hi/lo valid after edge k+WIDTH+1; busy high k..k+WIDTH+1 exclusive.
//  Back-to-back: start in the done cycle is accepted.
//  start while busy: ignored, no queueing. Invalid op (6,7): ignored, stays IDLE.
//  MULT/MULTU: {hi,lo} = full 2*WIDTH product, signed or unsigned.
//  DIV/DIVU: lo = quotient truncated toward zero, hi = remainder with dividend sign.
//  Divide by zero: no iteration error; hi = a, lo = all-ones, div0=1.
//  Signed DIV of -2^(WIDTH-1) by -1: lo = -2^(WIDTH-1) (wrap), hi = 0, div0=0.
//  done deasserts next cycle unconditionally; div0 holds until next done or reset.
// CONFIGURATION
//  MDU_MADD_EN defined: MADD/MADDU: {hi,lo} <= {hi,lo} + product (mod 2^(2*WIDTH)), {hi,lo} snapshot at accept edge.
//  MDU_MADD_EN undefined: ops 4/5 execute exactly as MULT/MULTU (overwrite, no accumulate); no snapshot regs.
// STRUCTURE
//  mdu_pkg: op encodings (MDU_MULT..MDU_MADDU), state enum (IDLE/RUN/FIX), helper function abs/negate.
//  Sub-module mdu_step: combinational single-iteration step (add-shift or trial-subtract) on {acc,q} for
//   selectable mode; top keeps FSM, counter, operand/sign regs, hi/lo.
// TESTING (WIDTH=32)
//  MULT a=0xFFFFFFFF b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFF9, done exactly 33 edges after accept, div0=0.
//  MULTU a=b=0xFFFFFFFF -> hi=0xFFFFFFFE lo=0x00000001.
//  DIV a=-7 b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000 hi=0.
//  DIVU a=100 b=0 -> hi=0x00000064 lo=0xFFFFFFFF div0=1; next MULTU 2*3 -> div0=0, lo=6.
//  start during busy and hi_we during busy -> no effect; RST=0 at cycle 10 of a DIV -> busy=0 hi=lo=0, no done.
//  MTLO 5, MTHI 0, MADD 3*4 -> macro on: lo=0x11 hi=0; macro off: lo=0xC hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op encodings, FSM states and
// small decode/negate helpers.
package mdu_pkg;

  typedef enum logic [2:0] {
    MDU_MULT  = 3'd0,
    MDU_MULTU = 3'd1,
    MDU_DIV   = 3'd2,
    MDU_DIVU  = 3'd3,
    MDU_MADD  = 3'd4,
    MDU_MADDU = 3'd5
  } mdu_op_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StFix  = 2'd2
  } mdu_state_e;

  // Widest value cond_neg handles; callers truncate back to their own width.
  localparam int unsigned MDU_MAX_W = 128;

  function automatic logic op_valid(input logic [2:0] op);
    return op <= 3'd5;
  endfunction

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  function automatic logic op_is_signed(input logic [2:0] op);
    return (op == MDU_MULT) || (op == MDU_DIV) || (op == MDU_MADD);
  endfunction

  function automatic logic op_is_madd(input logic [2:0] op);
    return (op == MDU_MADD) || (op == MDU_MADDU);
  endfunction

  // Two's complement negate when neg is set; low bits stay correct after truncation.
  function automatic logic [MDU_MAX_W-1:0] cond_neg(input logic [MDU_MAX_W-1:0] x,
                                                    input logic neg);
    return neg ? (~x + 1'b1) : x;
  endfunction

endpackage

// File: rtl/mdu_if.sv
// Start/busy/done handshake plus MTHI/MTLO write port and HI/LO readout of the mult/div unit.
interface mdu_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic             div0;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, div0, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, div0, hi, lo
  );
endinterface

// File: rtl/mdu_step.sv
// One iteration of the mult/div datapath on {acc,q}: shift-add multiply or restoring
// trial-subtract divide, selected by div_mode_i.
module mdu_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             div_mode_i,
  input  logic [WIDTH-1:0] acc_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] opnd_i,
  output logic [WIDTH-1:0] acc_o,
  output logic [WIDTH-1:0] q_o
);
  logic [WIDTH:0] sum;
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;

  always_comb begin
    sum  = q_i[0] ? ({1'b0, acc_i} + {1'b0, opnd_i}) : {1'b0, acc_i};
    rem  = {acc_i, q_i[WIDTH-1]};
    diff = rem - {1'b0, opnd_i};
    if (div_mode_i) begin
      // Top bit of diff is the borrow: set means the trial subtract failed.
      if (!diff[WIDTH]) begin
        acc_o = diff[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = rem[WIDTH-1:0];
        q_o   = {q_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = sum[WIDTH:1];
      q_o   = {sum[0], q_i[WIDTH-1:1]};
    end
  end
endmodule

// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO; one bit per cycle, IDLE -> RUN -> FIX.
// Define MDU_MADD_EN to make ops 4/5 accumulate into {hi,lo}; otherwise they act as MULT/MULTU.
module mult_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  localparam int unsigned CNT_W = $clog2(WIDTH)
) (
  input logic   CLK,
  input logic   RST,
  mdu_if.slave  bus
);
  localparam int unsigned DW = 2 * WIDTH;

  mdu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] opnd_q, opnd_d;
  logic             div_q, div_d;
  logic             neg_lo_q, neg_lo_d;
  logic             neg_hi_q, neg_hi_d;
  logic             bzero_q, bzero_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             done_q, done_d;
  logic             div0_q, div0_d;
`ifdef MDU_MADD_EN
  logic             madd_q, madd_d;
  logic [DW-1:0]    snap_q, snap_d;
`endif

  logic             accept;
  logic             a_neg, b_neg, op_div;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH-1:0] step_acc, step_q;
  logic [DW-1:0]    prod;

  mdu_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .div_mode_i(div_q),
    .acc_i     (acc_q),
    .q_i       (q_q),
    .opnd_i    (opnd_q),
    .acc_o     (step_acc),
    .q_o       (step_q)
  );

  always_comb begin
    accept = (state_q == StIdle) && bus.start && op_valid(bus.op);
    op_div = op_is_div(bus.op);
    a_neg  = op_is_signed(bus.op) && bus.a[WIDTH-1];
    b_neg  = op_is_signed(bus.op) && bus.b[WIDTH-1];
    abs_a  = WIDTH'(cond_neg(MDU_MAX_W'(bus.a), a_neg));
    abs_b  = WIDTH'(cond_neg(MDU_MAX_W'(bus.b), b_neg));
    prod   = DW'(cond_neg(MDU_MAX_W'({acc_q, q_q}), neg_lo_q));
`ifdef MDU_MADD_EN
    if (madd_q) prod = prod + snap_q;
`endif
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    q_d      = q_q;
    opnd_d   = opnd_q;
    div_d    = div_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    bzero_d  = bzero_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = 1'b0;
    div0_d   = div0_q;
`ifdef MDU_MADD_EN
    madd_d   = madd_q;
    snap_d   = snap_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d  = StRun;
          cnt_d    = '0;
          acc_d    = '0;
          div_d    = op_div;
          q_d      = op_div ? abs_a : abs_b;
          opnd_d   = op_div ? abs_b : abs_a;
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = a_neg;
          bzero_d  = op_div && (bus.b == '0);
`ifdef MDU_MADD_EN
          madd_d   = op_is_madd(bus.op);
          snap_d   = {hi_q, lo_q};
`endif
        end else begin
          if (bus.hi_we) hi_d = bus.wdata;
          if (bus.lo_we) lo_d = bus.wdata;
        end
      end
      StRun: begin
        acc_d = step_acc;
        q_d   = step_q;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = StFix;
      end
      StFix: begin
        state_d = StIdle;
        done_d  = 1'b1;
        div0_d  = bzero_q;
        if (div_q) begin
          // Divide by zero leaves acc holding |a|, so the sign fix restores hi = a.
          hi_d = WIDTH'(cond_neg(MDU_MAX_W'(acc_q), neg_hi_q));
          lo_d = bzero_q ? '1 : WIDTH'(cond_neg(MDU_MAX_W'(q_q), neg_lo_q));
        end else begin
          {hi_d, lo_d} = prod;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      acc_q    <= '0;
      q_q      <= '0;
      opnd_q   <= '0;
      div_q    <= 1'b0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      bzero_q  <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      div0_q   <= 1'b0;
`ifdef MDU_MADD_EN
      madd_q   <= 1'b0;
      snap_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      q_q      <= q_d;
      opnd_q   <= opnd_d;
      div_q    <= div_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      bzero_q  <= bzero_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      div0_q   <= div0_d;
`ifdef MDU_MADD_EN
      madd_q   <= madd_d;
      snap_q   <= snap_d;
`endif
    end
  end

  assign bus.busy = (state_q != StIdle);
  assign bus.done = done_q;
  assign bus.div0 = div0_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed self-checking bench for mult_div_unit at WIDTH=32.
module tb_mult_div_unit;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   lat;

  mdu_if #(.WIDTH(32)) bus ();

  mult_div_unit #(
    .WIDTH(32)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a start for one edge; returns #1 after the accept edge.
  task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge CLK);
    #1;
    bus.start = 1'b0;
  endtask

  // Counts edges until done is seen (sampled #1 after each edge); 0 on timeout.
  task automatic wait_done(output int edges);
    edges = 0;
    for (int i = 1; i <= 60; i++) begin
      @(posedge CLK);
      #1;
      if (bus.done) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp_hi,
                        input logic [31:0] exp_lo, input logic exp_div0);
    int edges;
    launch(op, a, b);
    wait_done(edges);
    check({tag, " latency"}, 64'(edges), 64'd33);
    check({tag, " hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, " lo"}, 64'(bus.lo), 64'(exp_lo));
    check({tag, " div0"}, 64'(bus.div0), 64'(exp_div0));
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = '0;
    bus.b     = '0;
    bus.hi_we = 1'b0;
    bus.lo_we = 1'b0;
    bus.wdata = '0;

    repeat (3) @(posedge CLK);
    #1;
    check("reset busy", 64'(bus.busy), 64'd0);
    check("reset done", 64'(bus.done), 64'd0);
    check("reset div0", 64'(bus.div0), 64'd0);
    check("reset hilo", {bus.hi, bus.lo}, 64'd0);
    RST = 1'b1;

    run_op("mult -1*7", 3'd0, 32'hFFFF_FFFF, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 1'b0);
    check("done cycle busy", 64'(bus.busy), 64'd0);
    @(posedge CLK);
    #1;
    check("done pulse ends", 64'(bus.done), 64'd0);

    run_op("multu max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
           1'b0);
    run_op("div -7/2", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("div min/-1", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 32'h8000_0000, 1'b0);
    run_op("divu 100/0", 3'd3, 32'd100, 32'd0, 32'h0000_0064, 32'hFFFF_FFFF, 1'b1);
    // Issued in the done cycle: must be accepted back-to-back.
    run_op("multu 2*3", 3'd1, 32'd2, 32'd3, 32'd0, 32'd6, 1'b0);
    run_op("divu 17/5", 3'd3, 32'd17, 32'd5, 32'd2, 32'd3, 1'b0);
    run_op("mult -3*-5", 3'd0, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'd0, 32'd15, 1'b0);

    // start and MTHI while busy are both ignored.
    launch(3'd1, 32'd5, 32'd5);
    repeat (3) @(posedge CLK);
    #1;
    bus.start = 1'b1;
    bus.op    = 3'd2;
    bus.a     = 32'd1;
    bus.b     = 32'd1;
    bus.hi_we = 1'b1;
    bus.wdata = 32'hDEAD_BEEF;
    @(posedge CLK);
    #1;
    bus.start = 1'b0;
    bus.hi_we = 1'b0;
    wait_done(lat);
    check("busy start latency", 64'(lat), 64'd29);
    check("busy ignore hilo", {bus.hi, bus.lo}, {32'd0, 32'd25});
    @(posedge CLK);
    #1;
    check("no queued op", 64'(bus.busy), 64'd0);

    launch(3'd6, 32'd1, 32'd1);
    check("invalid op idle", 64'(bus.busy), 64'd0);

    bus.lo_we = 1'b1;
    bus.wdata = 32'd5;
    @(posedge CLK);
    #1;
    bus.lo_we = 1'b0;
    bus.hi_we = 1'b1;
    bus.wdata = 32'd0;
    @(posedge CLK);
    #1;
    bus.hi_we = 1'b0;
    check("mtlo/mthi", {bus.hi, bus.lo}, {32'd0, 32'd5});
`ifdef MDU_MADD_EN
    run_op("madd 3*4", 3'd4, 32'd3, 32'd4, 32'd0, 32'h11, 1'b0);
`else
    run_op("madd 3*4", 3'd4, 32'd3, 32'd4, 32'd0, 32'hC, 1'b0);
`endif

    // Reset in the middle of a DIV aborts it with no done.
    run_op("div 1000/7", 3'd2, 32'd1000, 32'd7, 32'd6, 32'd142, 1'b0);
    launch(3'd2, 32'd1000, 32'd3);
    repeat (9) @(posedge CLK);
    #1;
    RST = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b1;
    check("abort busy", 64'(bus.busy), 64'd0);
    check("abort hilo", {bus.hi, bus.lo}, 64'd0);
    wait_done(lat);
    check("abort no done", 64'(lat), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
